// File: rtl/store_buffer.sv
// store_buffer: write-posting store buffer between the MEM stage and data memory.
//
// Stores are queued in a DEPTH-entry circular FIFO in one cycle and retired to data
// memory one per cycle whenever the pipeline leaves the memory port free. Loads are
// answered combinationally: a buffer hit forwards the youngest matching entry, a miss
// reads data memory directly. This block owns the data-memory port.
//
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge a store into an existing
// entry with the same word address (no allocation, no stall, no drain on full).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_read/cpu_write  load/store request from MEM stage (both set = load)
//   cpu_addr/cpu_wdata  byte address (bits [1:0] ignored) and store data
//   cpu_rdata           load data, 0 when no load
//   cpu_stall           store not accepted this cycle, retry
//   sb_empty            buffer holds no pending stores
//   mem_read/mem_write  data-memory MemRead/MemWrite
//   mem_addr/mem_wdata  data-memory Address/Write_data
//   mem_rdata           data-memory Read_data (combinational)
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        sb_empty,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    logic [29:0]     addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW:0]   count_q, count_d;

    logic            is_load, is_store, full;
    logic            hit, coalesce, push, drain;
    logic [31:0]     hit_data;
    logic [PtrW-1:0] hit_idx;

    // Walk entries oldest to youngest so the last match is the youngest one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (((PtrW + 1)'(k) < count_q) &&
                (addr_q[head_q + PtrW'(k)] == cpu_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = data_q[head_q + PtrW'(k)];
                hit_idx  = head_q + PtrW'(k);
            end
        end
    end

    always_comb begin
        is_load  = cpu_read;
        is_store = cpu_write & ~cpu_read;
        full     = (count_q == FullCnt);
`ifdef STORE_BUFFER_COALESCE_EN
        coalesce = is_store & hit;
`else
        coalesce = 1'b0;
`endif
        cpu_stall = is_store & full & ~coalesce;
        push      = is_store & ~full & ~coalesce;
        // A stalled full-buffer store still frees a slot; reset suppresses any write.
        drain     = ~reset & (count_q != '0) & ~cpu_read & (~cpu_write | (full & ~coalesce));

        sb_empty  = (count_q == '0);
        mem_read  = is_load & ~hit;
        mem_write = drain;
        mem_wdata = drain ? data_q[head_q] : 32'h0;
        if (drain) begin
            mem_addr = {addr_q[head_q], 2'b00};
        end else if (mem_read) begin
            mem_addr = cpu_addr;
        end else begin
            mem_addr = 32'h0;
        end

        if (!is_load) begin
            cpu_rdata = 32'h0;
        end else if (hit) begin
            cpu_rdata = hit_data;
        end else begin
            cpu_rdata = mem_rdata;
        end

        head_d  = head_q + PtrW'(drain);
        tail_d  = tail_q + PtrW'(push);
        count_d = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(drain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: validity is derived from head and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push) begin
                addr_q[tail_q] <= cpu_addr[31:2];
                data_q[tail_q] <= cpu_wdata;
            end else if (coalesce) begin
                data_q[hit_idx] <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        sb_empty;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];

    assign mem_rdata = tb_mem[mem_addr[7:2]];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .sb_empty  (sb_empty),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] o_rdata, o_maddr, o_mwdata;
    logic        o_stall, o_mrd, o_mwr, o_empty;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        stall;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        empty;
    } vec_t;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic stall, logic mrd, logic mwr,
                                logic [31:0] maddr, logic [31:0] mwdata, logic empty);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.stall = stall; v.mrd = mrd; v.mwr = mwr; v.maddr = maddr; v.mwdata = mwdata;
        v.empty = empty;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, model memory write, edge.
    task automatic cycle(input logic r, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        reset     = r;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clk);
        o_rdata  = cpu_rdata;
        o_stall  = cpu_stall;
        o_mrd    = mem_read;
        o_mwr    = mem_write;
        o_maddr  = mem_addr;
        o_mwdata = mem_wdata;
        o_empty  = sb_empty;
        if (mem_write) tb_mem[mem_addr[7:2]] = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    // Reference: a queue of pending stores plus a word-array memory.
    task automatic model_cycle(input string tag, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
        logic        st, hit, full, coal, e_stall, drain, e_empty;
        logic [31:0] hd, e_rdata, e_maddr, e_mwdata;
        int          hi;
        st = wr && !rd;
        hit = 1'b0;
        hd = 32'h0;
        hi = 0;
        foreach (q[i]) begin
            if (q[i].w == a[31:2]) begin
                hit = 1'b1;
                hd  = q[i].d;
                hi  = i;
            end
        end
        full = (q.size() == DEPTH);
`ifdef STORE_BUFFER_COALESCE_EN
        coal = st && hit;
`else
        coal = 1'b0;
`endif
        e_stall  = st && full && !coal;
        drain    = (q.size() > 0) && !rd && (!st || (full && !coal));
        e_rdata  = rd ? (hit ? hd : ref_mem[a[7:2]]) : 32'h0;
        e_maddr  = drain ? {q[0].w, 2'b00} : ((rd && !hit) ? a : 32'h0);
        e_mwdata = drain ? q[0].d : 32'h0;
        e_empty  = (q.size() == 0);

        cycle(1'b0, rd, wr, a, d);
        check({tag, " rdata"},  o_rdata,         e_rdata);
        check({tag, " stall"},  32'(o_stall),    32'(e_stall));
        check({tag, " mread"},  32'(o_mrd),      32'(rd && !hit));
        check({tag, " mwrite"}, 32'(o_mwr),      32'(drain));
        check({tag, " maddr"},  o_maddr,         e_maddr);
        check({tag, " mwdata"}, o_mwdata,        e_mwdata);
        check({tag, " empty"},  32'(o_empty),    32'(e_empty));

        if (drain) begin
            ref_mem[q[0].w[5:0]] = q[0].d;
            q.delete(0);
        end
        if (coal) begin
            q[hi].d = d;
        end else if (st && !e_stall) begin
            q.push_back('{w: a[31:2], d: d});
        end
    endtask

    initial begin
        logic [31:0] saved [3];
        logic        rd, wr;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h1000_0000 + 32'(i);
        tb_mem[2] = 32'h0000_0028;

        // rd wr addr wdata | rdata stall mrd mwr maddr mwdata empty
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 32'h0A, 32'h0, 32'h28, 0, 1, 0, 32'h0A, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00, 32'hA0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h04, 32'hA1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h08, 32'hA2, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h0C, 32'hA3, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h1C, 32'hA4, 32'h0, 1, 0, 1, 32'h00, 32'hA0, 0));
        vecs.push_back(mk(0, 1, 32'h1C, 32'hA4, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h04, 32'hA1, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h08, 32'hA2, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h0C, 32'hA3, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h1C, 32'hA4, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h20, 32'h1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h20, 32'h2, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 32'h20, 32'h0, 32'h2, 0, 0, 0, 32'h0, 32'h0, 0));
`ifdef STORE_BUFFER_COALESCE_EN
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h20, 32'h2, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
`else
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h20, 32'h1, 0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 1, 32'h20, 32'h2, 0));
`endif
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1));
        // Drained store is now served from memory.
        vecs.push_back(mk(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 0, 32'h10, 32'h0, 1));

        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rdata", i),  o_rdata,       vecs[i].rdata);
            check($sformatf("vec%0d stall", i),  32'(o_stall),  32'(vecs[i].stall));
            check($sformatf("vec%0d mread", i),  32'(o_mrd),    32'(vecs[i].mrd));
            check($sformatf("vec%0d mwrite", i), 32'(o_mwr),    32'(vecs[i].mwr));
            check($sformatf("vec%0d maddr", i),  o_maddr,       vecs[i].maddr);
            check($sformatf("vec%0d mwdata", i), o_mwdata,      vecs[i].mwdata);
            check($sformatf("vec%0d empty", i),  32'(o_empty),  32'(vecs[i].empty));
        end

        // Reset with three stores pending: nothing may reach memory.
        for (int i = 0; i < 3; i++) saved[i] = tb_mem[12 + i];
        cycle(1'b0, 1'b0, 1'b1, 32'h30, 32'hC0);
        cycle(1'b0, 1'b0, 1'b1, 32'h34, 32'hC1);
        cycle(1'b0, 1'b0, 1'b1, 32'h38, 32'hC2);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst_cycle mwrite", 32'(o_mwr), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            check($sformatf("post_rst%0d mwrite", i), 32'(o_mwr), 32'h0);
            check($sformatf("post_rst%0d empty", i), 32'(o_empty), 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_rst mem%0d", i), tb_mem[12 + i], saved[i]);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h34, 32'h0);
        check("post_rst load", o_rdata, saved[1]);

        // Randomized traffic against the queue model.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        q.delete();
        ref_mem = tb_mem;
        for (int n = 0; n < 1500; n++) begin
            r  = int'($urandom_range(0, 99));
            rd = (r < 30) || (r >= 95);
            wr = ((r >= 30) && (r < 70)) || (r >= 95);
            a  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            model_cycle($sformatf("rnd%0d", n), rd, wr, a, $urandom);
        end
        for (int n = 0; n < DEPTH + 2; n++) begin
            model_cycle($sformatf("drain%0d", n), 1'b0, 1'b0, 32'h0, 32'h0);
        end
        for (int i = 0; i < 64; i++) begin
            check($sformatf("final mem%0d", i), tb_mem[i], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-posting store buffer between the MEM pipeline stage and the data memory. Stores are accepted into a small FIFO in one cycle and retired to data memory one per cycle on cycles when the pipeline is not using the memory port. Loads check the buffer first: a hit forwards the youngest buffered data, a miss reads data memory combinationally. The block owns the data-memory port (MemRead/MemWrite/Address/Write_data/Read_data).

## Interface
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all buffer state.
- cpu_read  in  1  load request from the MEM stage.
- cpu_write  in  1  store request from the MEM stage.
- cpu_addr  in  32  byte address; bits [1:0] are ignored and matching uses addr[31:2].
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, combinational; 0 when cpu_read=0.
- cpu_stall  out  1  combinational; store not accepted this cycle, and the pipeline must hold and retry.
- sb_empty  out  1  registered-state flag; 1 when count=0.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_addr  out  32  to data memory Address.
- mem_wdata  out  32  to data memory Write_data.
- mem_rdata  in  32  from data memory Read_data, combinational.

## Operation
- State: circular FIFO of DEPTH entries {word_addr[29:0], data[31:0]}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Asserting cpu_read=1 and cpu_write=1 together is illegal. In that case the block treats the cycle as a load and ignores the store.
- Load, hit: at least one valid entry has word_addr = cpu_addr[31:2]. cpu_rdata is set to the data of the youngest matching entry. mem_read=0.
- Load, miss: mem_read=1, mem_addr=cpu_addr, cpu_rdata=mem_rdata.
- Store, count<DEPTH: the entry is written at tail, tail advances, count increments, and cpu_stall=0.
- Store, count=DEPTH: cpu_stall=1 and the store is not enqueued.
- Drain condition: count>0 AND cpu_read=0 AND (cpu_write=0 OR count=DEPTH). When it holds:
  - mem_write=1, mem_addr={head.word_addr,2'b00}, mem_wdata=head.data;
  - head advances and count decrements at the edge.
- In a full-buffer store cycle the drain frees a slot, so the stalled store is accepted on the retry cycle.
- In any cycle without a drain, mem_write=0 and mem_wdata=0. mem_addr is 0 unless a load miss drives it.
- Drain order is strict FIFO; stores reach memory in program order.
- There is no flush input. The pipeline polls sb_empty to wait for the buffer to quiesce.

## Timing
- Reset values:
  - count=0, head=tail=0, all entries invalid;
  - sb_empty=1;
  - with no requests: cpu_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
- Load latency is 0 cycles (combinational), whether it hits or misses.
- A store accepted at edge N is visible to loads from cycle N+1 and can reach memory at edge N+1 at the earliest.
- Any cycle with cpu_read=1 blocks the drain, even when the load hits.
- Full and store in the same cycle: exactly one stall cycle, then the retry is accepted. The buffer never overflows and never deadlocks.
- Pointer wrap: after DEPTH enqueues, tail returns to 0. Full and empty are distinguished by count, not by pointer equality.
- Reset mid-operation: pending entries are discarded, no mem_write is issued, and sb_empty=1 on the cycle after reset.

## Configuration
- STORE_BUFFER_COALESCE_EN defined:
  - a store whose word address matches a valid entry overwrites that entry's data in place;
  - no allocation, and no stall even when full;
  - when count=DEPTH, a matching store does not trigger a drain;
  - at most one entry per word address exists.
- Undefined: every store allocates a new entry. Duplicates are allowed, and forwarding selects the youngest.

## Test plan
- Reset, then idle -> sb_empty=1, cpu_stall=0, mem_write=0, mem_read=0.
- Store 0x10<-0xDEADBEEF, then next cycle load 0x10 -> cpu_rdata=0xDEADBEEF, mem_read=0, mem_write=0. Idle cycle after that -> mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, sb_empty=1 next cycle.
- DEPTH=4, back-to-back stores to 0x00,0x04,0x08,0x0C,0x1C -> 5th store gets cpu_stall=1 with mem_write=1, mem_addr=0x00 in that cycle. Retry accepted the next cycle, and idle cycles drain 0x04,0x08,0x0C,0x1C in order.
- Stores 0x20<-1 then 0x20<-2, then load 0x20 -> cpu_rdata=2. Idle drain:
  - without STORE_BUFFER_COALESCE_EN: writes 1 then 2;
  - with it: a single write of 2.
- Memory word 0x08 holds 0x28 and the buffer is empty; load 0x0A -> mem_read=1, mem_addr=0x0A, cpu_rdata=0x28.
- Three stores pending, then reset asserted for one cycle -> no mem_write in any later cycle, sb_empty=1 after reset.
